// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_wr_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    function automatic int idWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational round-robin picker: first set request above last, wrapping.
module fifo_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               pick_valid,
    output logic [ID_W-1:0]    pick_id
);

    logic            hiValid;
    logic            loValid;
    logic [ID_W-1:0] hiId;
    logic [ID_W-1:0] loId;

    // hi: first request above last; lo: first at or below last (the wrap)
    always_comb begin
        hiValid = 1'b0;
        loValid = 1'b0;
        hiId    = '0;
        loId    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) begin
                if (ID_W'(i) > last) begin
                    if (!hiValid) begin
                        hiValid = 1'b1;
                        hiId    = ID_W'(i);
                    end
                end else if (!loValid) begin
                    loValid = 1'b1;
                    loId    = ID_W'(i);
                end
            end
        end
        pick_valid = hiValid | loValid;
        pick_id    = hiValid ? hiId : loId;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among requesters.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic                        wrClk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        wrEn,
    output logic [DATA_W-1:0]           din,
    input  logic                        fifoFull,
    output logic                        grant_valid,
    output logic [idWidth(NUM_REQ)-1:0] grant_id,
    output logic [CNT_W-1:0]            wr_count
);

    localparam int ID_W = idWidth(NUM_REQ);
    localparam int BC_W = $clog2(BURST_LEN + 1);
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BURST_LEN - 1);

    arb_state_e      state;
    arb_state_e      stateNext;
    logic [ID_W-1:0] owner;
    logic [ID_W-1:0] ownerNext;
    logic [ID_W-1:0] lastGrant;
    logic [ID_W-1:0] lastGrantNext;
    logic [ID_W-1:0] pickId;
    logic            pickValid;
    logic [BC_W-1:0] burstCnt;
    logic [BC_W-1:0] burstCntNext;
    logic [CNT_W-1:0] wrCount;
    logic            ownerValid;
    logic [DATA_W-1:0] ownerData;
    logic            inGrant;
    logic            accept;

    fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req        (req_valid),
        .last       (lastGrant),
        .pick_valid (pickValid),
        .pick_id    (pickId)
    );

    always_comb begin
        ownerValid = 1'b0;
        ownerData  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == ID_W'(i)) begin
                ownerValid = req_valid[i];
                ownerData  = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Reset masks the held grant in the same cycle it is asserted.
    assign inGrant     = (state == ARB_GRANT) && !rst;
    assign accept      = inGrant && ownerValid && !fifoFull;
    assign wrEn        = accept;
    assign din         = inGrant ? ownerData : '0;
    assign grant_valid = inGrant;
    assign grant_id    = rst ? '0 : owner;
    assign wr_count    = wrCount;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (owner == ID_W'(i));
        end
    end

    always_comb begin
        stateNext     = state;
        ownerNext     = owner;
        burstCntNext  = burstCnt;
        lastGrantNext = lastGrant;
        unique case (state)
            ARB_IDLE: begin
                if (pickValid) begin
                    stateNext    = ARB_GRANT;
                    ownerNext    = pickId;
                    burstCntNext = '0;
                end
            end
            ARB_GRANT: begin
                if (accept) begin
                    burstCntNext = burstCnt + 1'b1;
                end
                if (!ownerValid || (accept && burstCnt == LAST_BEAT)) begin
                    stateNext     = ARB_IDLE;
                    lastGrantNext = owner;
                end
            end
            default: stateNext = ARB_IDLE;
        endcase
    end

    always_ff @(posedge wrClk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            owner     <= '0;
            lastGrant <= ID_W'(NUM_REQ - 1);
            burstCnt  <= '0;
            wrCount   <= '0;
        end else begin
            state     <= stateNext;
            owner     <= ownerNext;
            lastGrant <= lastGrantNext;
            burstCnt  <= burstCntNext;
            if (accept) begin
                wrCount <= wrCount + 1'b1;
            end
        end
    end

endmodule
